// File: rtl/axi_wr_dma_ctrl.sv
// axi_wr_dma_ctrl: write-side DMA sequencer in front of the AXI4 write master.
// Splits one SRAM->DDR job into master-legal chunks (16-bit length, no 4 KB
// crossing), pulses w_start per chunk and serves per-beat SRAM reads.
// Ports: job_* / busy / done / error    job interface to the NPU controller
//        w_*                            control and data to/from the master
//        sram_rd_*                      single-port SRAM, 1-cycle read latency
//        perf_cycles_o                  job cycle count
// Optional macro WR_DMA_PERF_EN enables the perf_cycles_o counter.
module axi_wr_dma_ctrl #(
   parameter int SRAM_ADDR_WIDTH = 32,
   parameter int CHUNK_BYTES     = 4096,
   parameter int START_TIMEOUT   = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       job_valid_i,
   output logic                       job_ready_o,
   input  logic [31:0]                job_ddr_addr_i,
   input  logic [SRAM_ADDR_WIDTH-1:0] job_sram_addr_i,
   input  logic [31:0]                job_byte_num_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       error_o,
   output logic [31:0]                w_target_slave_base_addr_o,
   output logic [15:0]                w_total_byte_num_o,
   output logic                       w_start_o,
   input  logic                       w_busy_i,
   input  logic                       w_error_i,
   input  logic [31:0]                w_sram_addr_i,
   input  logic                       w_sram_data_request_i,
   output logic [31:0]                w_data_o,
   output logic                       w_data_valid_o,
   output logic                       sram_rd_en_o,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_rd_addr_o,
   input  logic [31:0]                sram_rd_data_i,
   output logic [31:0]                perf_cycles_o
);

   localparam int AW = SRAM_ADDR_WIDTH;

   typedef enum logic [2:0] {
      IDLE, CALC, START, WAIT_RISE, WAIT_FALL, DONE
   } state_t;

   state_t        state, state_nx;
   logic [31:0]   ddr_addr, remaining, tmo;
   logic [AW-1:0] sram_base, sram_off;
   logic          abort, err_nx, accept;
   logic [31:0]   lim4k, chunk_nx, chunk_cur;
   logic          req_q;
   logic [31:0]   data_hold;

   assign accept      = job_valid_i && (state == IDLE);
   assign job_ready_o = (state == IDLE);
   assign busy_o      = (state != IDLE);
   assign done_o      = (state == DONE);
   assign w_start_o   = (state == START);

   // Bytes left before the next 4 KB boundary of the DDR address.
   assign lim4k     = 32'd4096 - {20'd0, ddr_addr[11:0]};
   assign chunk_cur = {16'd0, w_total_byte_num_o};

   always_comb begin
      chunk_nx = remaining;
      if (chunk_nx > 32'(CHUNK_BYTES)) chunk_nx = 32'(CHUNK_BYTES);
      if (chunk_nx > lim4k)            chunk_nx = lim4k;
   end

   always_comb begin
      state_nx = state;
      err_nx   = 1'b0;
      case (state)
         IDLE: if (accept) state_nx = CALC;
         CALC: begin
            if (remaining == 32'd0) begin
               state_nx = DONE;
            end else if (remaining[1:0] != 2'd0 || ddr_addr[1:0] != 2'd0) begin
               state_nx = DONE;
               err_nx   = 1'b1;
            end else begin
               state_nx = START;
            end
         end
         START: state_nx = WAIT_RISE;
         WAIT_RISE: begin
            if (w_busy_i) begin
               state_nx = WAIT_FALL;
            end else if (tmo == 32'(START_TIMEOUT - 1)) begin
               state_nx = DONE;
               err_nx   = 1'b1;
            end
         end
         WAIT_FALL: begin
            if (!w_busy_i) begin
               if (abort || w_error_i) begin
                  state_nx = DONE;
                  err_nx   = 1'b1;
               end else if (remaining == chunk_cur) begin
                  state_nx = DONE;
               end else begin
                  state_nx = CALC;
               end
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state                      <= IDLE;
         ddr_addr                   <= '0;
         remaining                  <= '0;
         sram_base                  <= '0;
         sram_off                   <= '0;
         tmo                        <= '0;
         abort                      <= 1'b0;
         error_o                    <= 1'b0;
         w_total_byte_num_o         <= '0;
         w_target_slave_base_addr_o <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            ddr_addr  <= job_ddr_addr_i;
            sram_base <= job_sram_addr_i;
            sram_off  <= '0;
            remaining <= job_byte_num_i;
            abort     <= 1'b0;
            error_o   <= 1'b0;
         end
         if (state == CALC && state_nx == START) begin
            w_total_byte_num_o         <= chunk_nx[15:0];
            w_target_slave_base_addr_o <= ddr_addr;
         end
         if (state == START)          tmo <= '0;
         else if (state == WAIT_RISE) tmo <= tmo + 32'd1;
         // A master error lets the current chunk drain, then aborts the job.
         if ((state == WAIT_RISE || state == WAIT_FALL) && w_error_i)
            abort <= 1'b1;
         if (state == WAIT_FALL && !w_busy_i) begin
            ddr_addr  <= ddr_addr + chunk_cur;
            sram_off  <= sram_off + AW'(chunk_cur);
            remaining <= remaining - chunk_cur;
         end
         if (state_nx == DONE && state != DONE)
            error_o <= err_nx;
      end
   end

   assign sram_rd_en_o   = w_sram_data_request_i;
   assign sram_rd_addr_o = sram_base + sram_off + w_sram_addr_i[AW-1:0];
   assign w_data_valid_o = req_q;
   assign w_data_o       = req_q ? sram_rd_data_i : data_hold;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         req_q     <= 1'b0;
         data_hold <= '0;
      end else begin
         req_q <= w_sram_data_request_i;
         if (req_q) data_hold <= sram_rd_data_i;
      end
   end

`ifdef WR_DMA_PERF_EN
   logic [31:0] perf;
   always_ff @(posedge clk) begin
      if (!rst_n)
         perf <= '0;
      else if (accept)
         perf <= '0;
      else if (busy_o && perf != 32'hFFFF_FFFF)
         perf <= perf + 32'd1;
   end
   assign perf_cycles_o = perf;
`else
   assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_axi_wr_dma_ctrl.sv
// tb_axi_wr_dma_ctrl: directed bench for axi_wr_dma_ctrl with a small
// master/SRAM model; immediate assertions at each check point.
module tb_axi_wr_dma_ctrl;

   localparam int TMO = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        job_valid_i;
   logic        job_ready_o;
   logic [31:0] job_ddr_addr_i;
   logic [31:0] job_sram_addr_i;
   logic [31:0] job_byte_num_i;
   logic        busy_o, done_o, error_o;
   logic [31:0] w_target_slave_base_addr_o;
   logic [15:0] w_total_byte_num_o;
   logic        w_start_o, w_busy_i, w_error_i;
   logic [31:0] w_sram_addr_i;
   logic        w_sram_data_request_i;
   logic [31:0] w_data_o;
   logic        w_data_valid_o, sram_rd_en_o;
   logic [31:0] sram_rd_addr_o;
   logic [31:0] sram_rd_data_i;
   logic [31:0] perf_cycles_o;

   int compares = 0;
   int fails    = 0;
   int n_start  = 0;
   int n_done   = 0;
   int n_busy   = 0;

   axi_wr_dma_ctrl #(
      .SRAM_ADDR_WIDTH(32), .CHUNK_BYTES(4096), .START_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
      .job_ddr_addr_i(job_ddr_addr_i), .job_sram_addr_i(job_sram_addr_i),
      .job_byte_num_i(job_byte_num_i),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
      .w_target_slave_base_addr_o(w_target_slave_base_addr_o),
      .w_total_byte_num_o(w_total_byte_num_o),
      .w_start_o(w_start_o), .w_busy_i(w_busy_i), .w_error_i(w_error_i),
      .w_sram_addr_i(w_sram_addr_i),
      .w_sram_data_request_i(w_sram_data_request_i),
      .w_data_o(w_data_o), .w_data_valid_o(w_data_valid_o),
      .sram_rd_en_o(sram_rd_en_o), .sram_rd_addr_o(sram_rd_addr_o),
      .sram_rd_data_i(sram_rd_data_i), .perf_cycles_o(perf_cycles_o)
   );

   always #5 clk = ~clk;

   // SRAM model: data is a tag plus the low address bits; garbage when idle.
   always @(posedge clk) begin
      if (sram_rd_en_o) sram_rd_data_i <= {8'hA5, sram_rd_addr_o[23:0]};
      else              sram_rd_data_i <= 32'hDEAD_BEEF;
   end

   always @(posedge clk) begin
      if (w_start_o) n_start++;
      if (done_o)    n_done++;
      if (busy_o)    n_busy++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compares++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue_job(input logic [31:0] ddr, input logic [31:0] sram,
                            input logic [31:0] bytes);
      @(negedge clk);
      chk("job_ready_idle", job_ready_o, 1);
      job_valid_i     = 1'b1;
      job_ddr_addr_i  = ddr;
      job_sram_addr_i = sram;
      job_byte_num_i  = bytes;
      @(negedge clk);
      job_valid_i = 1'b0;
   endtask

   task automatic run_chunk(input logic [31:0] ea, input logic [15:0] el,
                            input logic [31:0] es);
      bit seen;
      int n;
      logic [31:0] prev;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (w_start_o) seen = 1'b1;
      end
      chk("start_seen", 32'(seen), 1);
      chk("chunk_addr", w_target_slave_base_addr_o, ea);
      chk("chunk_len", 32'(w_total_byte_num_o), 32'(el));
      @(negedge clk);
      @(negedge clk);
      w_busy_i = 1'b1;
      n = int'(el) / 4;
      prev = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk("beat_valid", 32'(w_data_valid_o), 1);
            chk("beat_data", w_data_o, {8'hA5, prev[23:0]});
         end
         w_sram_data_request_i = 1'b1;
         w_sram_addr_i = 32'(4 * i);
         #1;
         prev = es + 32'(4 * i);
         chk("rd_en", 32'(sram_rd_en_o), 1);
         chk("rd_addr", sram_rd_addr_o, prev);
      end
      @(negedge clk);
      chk("last_valid", 32'(w_data_valid_o), 1);
      chk("last_data", w_data_o, {8'hA5, prev[23:0]});
      w_sram_data_request_i = 1'b0;
      @(negedge clk);
      chk("idle_valid", 32'(w_data_valid_o), 0);
      chk("data_hold", w_data_o, {8'hA5, prev[23:0]});
      w_busy_i = 1'b0;
   endtask

   task automatic wait_done(input string tag, input logic exp_err);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (done_o) seen = 1'b1;
      end
      chk({tag, "_done_seen"}, 32'(seen), 1);
      chk({tag, "_error"}, 32'(error_o), 32'(exp_err));
   endtask

   initial begin
      int s0, d0, b0;
      rst_n = 1'b0;
      job_valid_i = 1'b0;
      job_ddr_addr_i = '0;
      job_sram_addr_i = '0;
      job_byte_num_i = '0;
      w_busy_i = 1'b0;
      w_error_i = 1'b0;
      w_sram_addr_i = '0;
      w_sram_data_request_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(job_ready_o), 1);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_done", 32'(done_o), 0);
      chk("rst_error", 32'(error_o), 0);
      chk("rst_start", 32'(w_start_o), 0);
      chk("rst_len", 32'(w_total_byte_num_o), 0);
      chk("rst_addr", w_target_slave_base_addr_o, 0);
      chk("rst_wvalid", 32'(w_data_valid_o), 0);
      chk("rst_wdata", w_data_o, 0);
      chk("rst_perf", perf_cycles_o, 0);
      rst_n = 1'b1;

      // Single 4 KB chunk.
      s0 = n_start; d0 = n_done; b0 = n_busy;
      issue_job(32'h0, 32'h100, 32'd4096);
      chk("busy_in_job", 32'(busy_o), 1);
      chk("ready_in_job", 32'(job_ready_o), 0);
      run_chunk(32'h0, 16'h1000, 32'h100);
      wait_done("j1", 1'b0);
      repeat (3) @(negedge clk);
      chk("j1_starts", 32'(n_start - s0), 1);
      chk("j1_dones", 32'(n_done - d0), 1);
`ifdef WR_DMA_PERF_EN
      chk("j1_perf", perf_cycles_o, 32'(n_busy - b0));
      repeat (5) @(negedge clk);
      chk("j1_perf_hold", perf_cycles_o, 32'(n_busy - b0));
`else
      chk("j1_perf_zero", perf_cycles_o, 32'(b0 - b0));
`endif

      // 4 KB boundary splitting: three chunks.
      s0 = n_start; d0 = n_done;
      issue_job(32'h0F00, 32'h200, 32'h2000);
      run_chunk(32'h0F00, 16'h0100, 32'h200);
      run_chunk(32'h1000, 16'h1000, 32'h300);
      run_chunk(32'h2000, 16'h0F00, 32'h1300);
      wait_done("j2", 1'b0);
      repeat (3) @(negedge clk);
      chk("j2_starts", 32'(n_start - s0), 3);
      chk("j2_dones", 32'(n_done - d0), 1);

      // Zero bytes: done two cycles after accept, no start.
      s0 = n_start;
      issue_job(32'h40, 32'h0, 32'd0);
      chk("z_not_yet", 32'(done_o), 0);
      @(negedge clk);
      chk("z_done", 32'(done_o), 1);
      chk("z_error", 32'(error_o), 0);

      // Unaligned byte count: error, no start.
      issue_job(32'h40, 32'h0, 32'd6);
      @(negedge clk);
      chk("u_done", 32'(done_o), 1);
      chk("u_error", 32'(error_o), 1);
      @(negedge clk);
      chk("u_err_held", 32'(error_o), 1);
      chk("zu_starts", 32'(n_start - s0), 0);

      // Start timeout: master never raises busy.
      issue_job(32'h0, 32'h0, 32'd16);
      chk("t_err_cleared", 32'(error_o), 0);
      for (int i = 0; i < 10 && !w_start_o; i++) @(negedge clk);
      chk("t_start", 32'(w_start_o), 1);
      repeat (TMO) @(negedge clk);
      chk("t_not_early", 32'(done_o), 0);
      @(negedge clk);
      chk("t_done", 32'(done_o), 1);
      chk("t_error", 32'(error_o), 1);

      // Master error during chunk 1 of 3.
      s0 = n_start;
      issue_job(32'h0F00, 32'h0, 32'h2000);
      for (int i = 0; i < 10 && !w_start_o; i++) @(negedge clk);
      chk("e_start", 32'(w_start_o), 1);
      chk("e_len", 32'(w_total_byte_num_o), 32'h100);
      @(negedge clk); w_busy_i = 1'b1;
      @(negedge clk); w_error_i = 1'b1;
      @(negedge clk); w_error_i = 1'b0;
      repeat (4) @(negedge clk);
      chk("e_still_busy", 32'(busy_o), 1);
      w_busy_i = 1'b0;
      wait_done("e", 1'b1);
      repeat (5) @(negedge clk);
      chk("e_starts", 32'(n_start - s0), 1);

      // Reset in the middle of a chunk.
      d0 = n_done;
      issue_job(32'h0, 32'h0, 32'h1000);
      for (int i = 0; i < 10 && !w_start_o; i++) @(negedge clk);
      @(negedge clk); w_busy_i = 1'b1;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk);
      chk("r_ready", 32'(job_ready_o), 1);
      chk("r_busy", 32'(busy_o), 0);
      chk("r_len", 32'(w_total_byte_num_o), 0);
      chk("r_addr", w_target_slave_base_addr_o, 0);
      chk("r_error", 32'(error_o), 0);
      chk("r_perf", perf_cycles_o, 0);
      rst_n = 1'b1;
      w_busy_i = 1'b0;
      repeat (10) @(negedge clk);
      chk("r_no_done", 32'(n_done - d0), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end

endmodule
